serial_mult_param: RTL and testbench
====================================

# serial_mult_param

Parametrised shift-add serial multiplier: WIDTH x WIDTH operands, 2*WIDTH product, one multiplier bit per clock. It adds selectable signed (two's complement) or unsigned mode, a start/busy/done handshake and asynchronous reset. It is the successor to the fixed 4x4 serial multiplier and is a drop-in arithmetic unit for sequential datapaths where area matters more than throughput.

## Interface
Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the rising edge of clk; accepted only when busy=0.
- signed_mode  input  1  1 = a and b are two's complement, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled on the accept edge.
- b  input  WIDTH  multiplier; sampled on the accept edge.
- p  output  2*WIDTH  product; registered; holds the last result until the next completion.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  one-cycle pulse; p is valid in the same cycle.

## Operation
- States: IDLE, RUN.
  - IDLE: start=1 -> RUN; capture operands and mode; clear the accumulator; load the bit counter to WIDTH.
  - RUN: each edge, process one multiplier bit, LSB first; decrement the counter.
  - RUN: counter reaches 0 -> IDLE; write p; pulse done.
- Signed handling uses sign-magnitude conversion at accept:
  - Store |a| and |b| as WIDTH-bit unsigned values. -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1), which fits in WIDTH bits.
  - Store neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Unsigned mode: operands are used as-is and neg=0.
- Iteration:
  - If the current multiplier bit is 1: acc += magnitude_a << bit_index.
  - Shift the multiplier register right by one.
  - acc is 2*WIDTH bits and never overflows, because the magnitude product is at most 2^(2*WIDTH-2) in signed mode and (2^WIDTH-1)^2 in unsigned mode.
- Completion: p <= neg ? -acc_final : acc_final, modulo 2^(2*WIDTH). The negation is applied combinationally on the final iteration's sum, so no extra cycle is needed.
- Operand inputs are don't-care except on the accept edge. Changing them while busy has no effect.

## Timing
- Reset values: p=0, busy=0, done=0, state=IDLE, accumulator and counter cleared.
- Reset is asynchronous: it takes effect immediately, even mid-operation.
  - The in-flight result is discarded; p returns to 0 and no done is produced.
- Accept edge E (start=1, busy=0):
  - busy=1 from E until edge E+WIDTH.
  - At edge E+WIDTH: p is updated, done=1 and busy=0, all for exactly one cycle.
- Latency: WIDTH clock cycles from the accept edge to done. Throughput is one result per WIDTH cycles.
- start=1 while busy=1 is ignored and is not queued.
- start=1 in the cycle where done=1 is accepted at the next edge (busy=0 in that cycle), giving back-to-back operation with no dead cycle.
- start held high continuously: a new operation is accepted every WIDTH+1 cycles (WIDTH cycles busy, one cycle of done).
- done is never asserted for more than one consecutive cycle. p changes only at completion edges or on reset.

## Test plan
- WIDTH=4, unsigned, a=10, b=13, start pulsed for 1 cycle -> busy high for 4 cycles; done pulses at accept+4; p=8'd130 and holds afterwards.
- WIDTH=4, signed, a=4'b1010 (-6), b=4'd5 -> p=8'hE2 (-30). Then a=-8, b=-8 -> p=8'h40 (64). Then a=-8, b=7 -> p=8'hC8 (-56).
- WIDTH=4, unsigned, a=15, b=15 -> p=8'd225. Then a=0, b=9 -> p=0; done still pulses at accept+4.
- Start during busy: accept a=3, b=3, then assert start with a=7, b=7 at accept+2 -> only one done, with p=9. Start asserted in the done cycle with a=7, b=7 -> second done 5 cycles after the first, p=49.
- Reset mid-op: assert rst asynchronously at accept+2 (between edges) -> p, busy and done go to 0 immediately; no done follows. After release, a fresh start completes normally.
- WIDTH=8 signed random sweep (≥1000 vectors) plus corners -128, -1, 0, 127 in both modes -> p matches the reference product modulo 2^16 and latency is always 8.

Source files
------------

// File: rtl/serial_mult_param.sv
// serial_mult_param: shift-add serial multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed operands are converted to sign-magnitude when a request is accepted.
// The magnitude product is then built one multiplier bit per clock, LSB first,
// and the sign is restored when the final partial sum is written to p.
//
// state | meaning
// IDLE  | waiting for start; p holds the last result
// RUN   | one multiplier bit consumed per clock; cnt counts the bits still to go
module serial_mult_param #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] sum;
  logic [2*WIDTH-1:0] result;

  // Operand magnitudes.
  // The most negative value maps onto 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    mag_a = (signed_mode && a[WIDTH-1]) ? -a : a;
    mag_b = (signed_mode && b[WIDTH-1]) ? -b : b;
  end

  // Partial sum for the current bit.
  // The sign is applied to the same sum, so the final iteration writes p directly.
  always_comb begin
    sum    = acc + (mplier[0] ? mcand : '0);
    result = neg ? -sum : sum;
  end

  assign busy = (state == RUN);

  // Sequencing, accumulation and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      p      <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            cnt    <= CW'(WIDTH);
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        RUN: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= IDLE;
            p     <= result;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mult_param.sv
// tb_serial_mult_param: checks a WIDTH=4 and a WIDTH=8 instance against a plain
// integer-arithmetic product model.
module tb_serial_mult_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sm;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic        busy4, done4, busy8, done8;

  int n_tests = 0;
  int n_fail  = 0;

  serial_mult_param #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm),
    .a(a4), .b(b4), .p(p4), .busy(busy4), .done(done4)
  );

  serial_mult_param #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm),
    .a(a8), .b(b8), .p(p8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Product of the operands read as integers, reduced modulo 2^(2w).
  function automatic logic [63:0] ref_prod(input int w, input bit s,
                                           input logic [31:0] x, input logic [31:0] y);
    longint mask, xv, yv, pr;
    mask = (longint'(1) << w) - 1;
    xv = longint'(x) & mask;
    yv = longint'(y) & mask;
    if (s) begin
      if (xv >= (longint'(1) << (w - 1))) xv = xv - (longint'(1) << w);
      if (yv >= (longint'(1) << (w - 1))) yv = yv - (longint'(1) << w);
    end
    pr = xv * yv;
    return 64'(pr & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic logic get_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic [63:0] get_p(input int w);
    return (w == 4) ? 64'(p4) : 64'(p8);
  endfunction

  task automatic drive(input int w, input bit s, input logic [31:0] x, input logic [31:0] y);
    sm = s;
    if (w == 4) begin
      start4 = 1'b1; a4 = x[3:0]; b4 = y[3:0];
    end else begin
      start8 = 1'b1; a8 = x[7:0]; b8 = y[7:0];
    end
  endtask

  task automatic drop_start();
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Counts negedges until done is seen; k = -1 if the bound runs out.
  task automatic wait_done(input int w, output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (get_done(w)) begin
        k = i;
        break;
      end
    end
    if (k < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // Full operation: accept, latency, product, one-cycle done, p holds afterwards.
  task automatic do_op(input int w, input bit s, input logic [31:0] x, input logic [31:0] y,
                       input string tag);
    int k;
    logic [63:0] exp;
    exp = ref_prod(w, s, x, y);
    @(negedge clk);
    drive(w, s, x, y);
    @(negedge clk);
    drop_start();
    chk({tag, "_busy_after_accept"}, 64'(get_busy(w)), 64'd1);
    wait_done(w, k);
    chk({tag, "_latency"}, 64'(k), 64'(w));
    chk({tag, "_p"}, get_p(w), exp);
    chk({tag, "_busy_at_done"}, 64'(get_busy(w)), 64'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(get_done(w)), 64'd0);
    chk({tag, "_p_hold"}, get_p(w), exp);
  endtask

  initial begin
    int k;
    int cnt;
    logic [7:0] corners [4];
    corners[0] = 8'h80; corners[1] = 8'hFF; corners[2] = 8'h00; corners[3] = 8'h7F;

    rst = 1'b1; sm = 1'b0;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_p4", 64'(p4), 64'd0);
    chk("reset_busy4", 64'(busy4), 64'd0);
    chk("reset_done4", 64'(done4), 64'd0);
    chk("reset_p8", 64'(p8), 64'd0);
    chk("reset_busy8", 64'(busy8), 64'd0);
    rst = 1'b0;

    do_op(4, 1'b0, 10, 13, "u_10x13");
    chk("u_10x13_const", 64'(p4), 64'd130);
    do_op(4, 1'b1, 4'hA, 5, "s_m6x5");
    chk("s_m6x5_const", 64'(p4), 64'hE2);
    do_op(4, 1'b1, 4'h8, 4'h8, "s_m8xm8");
    chk("s_m8xm8_const", 64'(p4), 64'h40);
    do_op(4, 1'b1, 4'h8, 7, "s_m8x7");
    chk("s_m8x7_const", 64'(p4), 64'hC8);
    do_op(4, 1'b0, 15, 15, "u_15x15");
    do_op(4, 1'b0, 0, 9, "u_0x9");

    // Start during busy is ignored; start in the done cycle chains directly.
    @(negedge clk);
    drive(4, 1'b0, 3, 3);
    @(negedge clk);
    drop_start();
    @(negedge clk);
    drive(4, 1'b0, 7, 7);
    @(negedge clk);
    drop_start();
    wait_done(4, k);
    chk("ignore_start_latency", 64'(k), 64'd2);
    chk("ignore_start_p", 64'(p4), 64'd9);
    drive(4, 1'b0, 7, 7);
    @(negedge clk);
    drop_start();
    chk("chain_busy", 64'(busy4), 64'd1);
    wait_done(4, k);
    chk("chain_gap", 64'(k + 1), 64'd5);
    chk("chain_p", 64'(p4), 64'd49);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done4) cnt++;
    end
    chk("no_extra_done", 64'(cnt), 64'd0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    drive(4, 1'b0, 3, 3);
    @(negedge clk);
    drop_start();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_p", 64'(p4), 64'd0);
    chk("rst_mid_busy", 64'(busy4), 64'd0);
    chk("rst_mid_done", 64'(done4), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done4) cnt++;
    end
    chk("rst_no_done", 64'(cnt), 64'd0);
    do_op(4, 1'b0, 6, 11, "after_rst");

    // WIDTH=8 corners in both modes.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          do_op(8, m[0], 32'(corners[i]), 32'(corners[j]), "w8_corner");

    // WIDTH=8 random sweep, signed then unsigned.
    for (int i = 0; i < 1000; i++)
      do_op(8, 1'b1, $urandom, $urandom, "w8_rand_s");
    for (int i = 0; i < 200; i++)
      do_op(8, 1'b0, $urandom, $urandom, "w8_rand_u");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
